// File: rtl/multi_sig_acc_if.sv
// Sample-in / channel-sum-out bundle for multi_sig_acc.
// The master drives samples and frame marks; the slave returns per-channel results.
interface multi_sig_acc_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int CH_W       = 2
);
  logic [DIN_WIDTH-1:0]  din;
  logic                  din_valid;
  logic                  last;
  logic [DOUT_WIDTH-1:0] dout;
  logic [CH_W-1:0]       dout_ch;
  logic                  dout_valid;
  logic                  dout_ovf;

  modport master (
    output din, din_valid, last,
    input  dout, dout_ch, dout_valid, dout_ovf
  );

  modport slave (
    input  din, din_valid, last,
    output dout, dout_ch, dout_valid, dout_ovf
  );
endinterface

// File: rtl/sig_sat_add.sv
// Combinational signed adder with one guard bit; clamps or wraps on overflow.
module sig_sat_add #(
  parameter int                WIDTH    = 32,
  parameter int                SATURATE = 1,
  parameter logic [WIDTH-1:0]  SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}},
  parameter logic [WIDTH-1:0]  SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);
  logic [WIDTH:0] sum_full_s;

  assign sum_full_s = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
  assign ovf_o      = sum_full_s[WIDTH] ^ sum_full_s[WIDTH-1];

  // Select clamped or wrapped result.
  always_comb begin
    sum_o = sum_full_s[WIDTH-1:0];
    if (ovf_o && (SATURATE != 0)) begin
      sum_o = sum_full_s[WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = sum_full_s[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/multi_sig_acc.sv
// Interleaved multi-channel fixed-point accumulator; each honoured frame end
// snapshots all channel sums into a shadow bank that is streamed out one per cycle.
module multi_sig_acc #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_INT    = 4,
  parameter int DOUT_WIDTH = 32,
  parameter int DOUT_INT   = 14,
  parameter int CHANNELS   = 4,
  parameter int SATURATE   = 1,
  localparam int CH_W      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic                  last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [CH_W-1:0]       dout_ch,
  output logic                  dout_valid,
  output logic                  dout_ovf
);
  localparam int DF    = DIN_WIDTH - DIN_INT;
  localparam int OF    = DOUT_WIDTH - DOUT_INT;
  localparam int SHIFT = OF - DF;
  localparam logic [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [CH_W-1:0]       LAST_CH = CH_W'(CHANNELS - 1);

  if ((DOUT_INT < DIN_INT) || (OF < DF) || (CHANNELS < 2)) begin : g_bad_cfg
    $error("multi_sig_acc: unsupported format or channel configuration");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_DUMP = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        dump_idx_q, dump_idx_d;
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
  logic                   first_q, first_d;
  logic [DOUT_WIDTH-1:0]  acc_q     [CHANNELS];
  logic [DOUT_WIDTH-1:0]  shd_acc_q [CHANNELS];
  logic [CHANNELS-1:0]    ovf_q;
  logic [CHANNELS-1:0]    shd_ovf_q;
  logic [DOUT_WIDTH-1:0]  dout_q, dout_d;
  logic [CH_W-1:0]        dout_ch_q, dout_ch_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   dout_ovf_q, dout_ovf_d;

  logic [DOUT_WIDTH-1:0]  aligned_s;
  logic [DOUT_WIDTH-1:0]  add_b_s;
  logic [DOUT_WIDTH-1:0]  sum_s;
  logic                   sat_ovf_s;
  logic                   ovf_new_s;
  logic                   honoured_s;

  assign aligned_s  = DOUT_WIDTH'($signed(din)) << SHIFT;
  assign add_b_s    = first_q ? '0 : acc_q[ch_cnt_q];
  assign ovf_new_s  = sat_ovf_s | (~first_q & ovf_q[ch_cnt_q]);
  assign honoured_s = din_valid && last && (ch_cnt_q == LAST_CH);

  sig_sat_add #(
    .WIDTH    (DOUT_WIDTH),
    .SATURATE (SATURATE),
    .SAT_MAX  (SAT_MAX),
    .SAT_MIN  (SAT_MIN)
  ) u_add (
    .a_i   (aligned_s),
    .b_i   (add_b_s),
    .sum_o (sum_s),
    .ovf_o (sat_ovf_s)
  );

  // Channel pointer and first-round flag; the flag only drops once a full round completes.
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    first_d  = first_q;
    if (din_valid) begin
      ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_W'(1);
      first_d  = (ch_cnt_q == LAST_CH) ? honoured_s : first_q;
    end else begin
      ch_cnt_d = ch_cnt_q;
      first_d  = first_q;
    end
  end

  // Accumulator bank and sticky per-channel overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (din_valid) begin
      acc_q[ch_cnt_q] <= sum_s;
      ovf_q[ch_cnt_q] <= ovf_new_s;
    end
  end

  // Shadow snapshot, including the last channel's update landing on the same edge.
  always_ff @(posedge clk) begin
    if (honoured_s) begin
      for (int i = 0; i < CHANNELS - 1; i++) begin
        shd_acc_q[i] <= acc_q[i];
        shd_ovf_q[i] <= ovf_q[i];
      end
      shd_acc_q[CHANNELS-1] <= sum_s;
      shd_ovf_q[CHANNELS-1] <= ovf_new_s;
    end
  end

  // Dump sequencer and registered output selection.
  always_comb begin
    state_d      = state_q;
    dump_idx_d   = dump_idx_q;
    dout_d       = '0;
    dout_ch_d    = '0;
    dout_valid_d = 1'b0;
    dout_ovf_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d    = honoured_s ? ST_DUMP : ST_IDLE;
        dump_idx_d = '0;
      end
      ST_DUMP: begin
        dout_d       = shd_acc_q[dump_idx_q];
        dout_ch_d    = dump_idx_q;
        dout_valid_d = 1'b1;
        dout_ovf_d   = shd_ovf_q[dump_idx_q];
        if (dump_idx_q == LAST_CH) begin
          state_d    = honoured_s ? ST_DUMP : ST_IDLE;
          dump_idx_d = '0;
        end else begin
          state_d    = ST_DUMP;
          dump_idx_d = dump_idx_q + CH_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        dump_idx_d = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dump_idx_q   <= '0;
      ch_cnt_q     <= '0;
      first_q      <= 1'b1;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_idx_q   <= dump_idx_d;
      ch_cnt_q     <= ch_cnt_d;
      first_q      <= first_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      dout_ovf_q   <= dout_ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign dout_ovf   = dout_ovf_q;
endmodule

// File: tb/tb_multi_sig_acc.sv
// Bench for multi_sig_acc: three instances (default, 20-bit saturating, 20-bit wrapping)
// share one stimulus stream; a sum-level reference model predicts every output cycle.
module tb_multi_sig_acc;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_sig_acc_if #(.DIN_WIDTH(16), .DOUT_WIDTH(32), .CH_W(2)) bus0 ();
  multi_sig_acc_if #(.DIN_WIDTH(16), .DOUT_WIDTH(20), .CH_W(2)) bus1 ();
  multi_sig_acc_if #(.DIN_WIDTH(16), .DOUT_WIDTH(20), .CH_W(2)) bus2 ();

  multi_sig_acc dut0 (
    .clk(clk), .rst(rst), .din(bus0.din), .din_valid(bus0.din_valid), .last(bus0.last),
    .dout(bus0.dout), .dout_ch(bus0.dout_ch), .dout_valid(bus0.dout_valid), .dout_ovf(bus0.dout_ovf)
  );
  multi_sig_acc #(.DOUT_WIDTH(20), .DOUT_INT(8), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .din(bus1.din), .din_valid(bus1.din_valid), .last(bus1.last),
    .dout(bus1.dout), .dout_ch(bus1.dout_ch), .dout_valid(bus1.dout_valid), .dout_ovf(bus1.dout_ovf)
  );
  multi_sig_acc #(.DOUT_WIDTH(20), .DOUT_INT(8), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .din(bus2.din), .din_valid(bus2.din_valid), .last(bus2.last),
    .dout(bus2.dout), .dout_ch(bus2.dout_ch), .dout_valid(bus2.dout_valid), .dout_ovf(bus2.dout_ovf)
  );

  typedef struct {
    int     cyc;
    int     ch;
    longint val;
    bit     ovf;
    int     inst;
  } exp_t;

  typedef struct packed {
    logic [3:0][15:0] din;
    int               rounds;
    logic [3:0][31:0] exp;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     m_cnt;
  bit     m_first;
  longint m_acc [NI][4];
  bit     m_ovf [NI][4];
  exp_t   expq [$];
  vec_t   vecs [3];

  function automatic int w_of(input int i);
    return (i == 0) ? 32 : 20;
  endfunction

  function automatic int shift_of(input int i);
    return (i == 0) ? 6 : 0;
  endfunction

  function automatic bit sat_of(input int i);
    return (i != 2);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer sums, range-checked against the output width.
  task automatic model_step(input logic [15:0] d, input bit v, input bit l, input bit r);
    bit     hon;
    longint x, s, hi, lo;
    bit     o;
    exp_t   e;
    if (r) begin
      m_cnt   = 0;
      m_first = 1'b1;
      for (int i = 0; i < NI; i++) for (int k = 0; k < 4; k++) m_ovf[i][k] = 1'b0;
      expq.delete();
    end else if (v) begin
      hon = l && (m_cnt == 3);
      for (int i = 0; i < NI; i++) begin
        x  = longint'($signed(d)) * (longint'(1) << shift_of(i));
        s  = m_first ? x : m_acc[i][m_cnt] + x;
        hi = (longint'(1) << (w_of(i) - 1)) - 1;
        lo = -hi - 1;
        o  = (s > hi) || (s < lo);
        if (o && sat_of(i)) s = (s > hi) ? hi : lo;
        else if (s > hi) s = s - (longint'(1) << w_of(i));
        else if (s < lo) s = s + (longint'(1) << w_of(i));
        m_ovf[i][m_cnt] = o || (!m_first && m_ovf[i][m_cnt]);
        m_acc[i][m_cnt] = s;
      end
      if (hon) begin
        for (int k = 0; k < 4; k++) begin
          for (int i = 0; i < NI; i++) begin
            e.cyc = cyc + 2 + k; e.ch = k; e.val = m_acc[i][k]; e.ovf = m_ovf[i][k]; e.inst = i;
            expq.push_back(e);
          end
        end
      end
      if (m_cnt == 3) m_first = hon;
      m_cnt = (m_cnt + 1) % 4;
    end
  endtask

  task automatic monitor();
    exp_t   e;
    bit     ev, av, eo, ao;
    int     ech, ach;
    longint evl, avl, mask;
    for (int i = 0; i < NI; i++) begin
      ev = 1'b0; ech = 0; evl = 0; eo = 1'b0;
      if (expq.size() > 0 && expq[0].cyc == cyc && expq[0].inst == i) begin
        e = expq.pop_front();
        ev = 1'b1; ech = e.ch; evl = e.val; eo = e.ovf;
      end
      mask = (longint'(1) << w_of(i)) - 1;
      av  = (i == 0) ? bus0.dout_valid : (i == 1) ? bus1.dout_valid : bus2.dout_valid;
      ach = (i == 0) ? int'(bus0.dout_ch) : (i == 1) ? int'(bus1.dout_ch) : int'(bus2.dout_ch);
      ao  = (i == 0) ? bus0.dout_ovf : (i == 1) ? bus1.dout_ovf : bus2.dout_ovf;
      avl = (i == 0) ? longint'(bus0.dout) : (i == 1) ? longint'(bus1.dout) : longint'(bus2.dout);
      check($sformatf("mon%0d.valid@%0d", i, cyc), longint'(av), longint'(ev));
      check($sformatf("mon%0d.ch@%0d", i, cyc), longint'(ach), longint'(ech));
      check($sformatf("mon%0d.dout@%0d", i, cyc), avl, evl & mask);
      check($sformatf("mon%0d.ovf@%0d", i, cyc), longint'(ao), longint'(eo));
    end
  endtask

  task automatic cycle(input logic [15:0] d, input bit v, input bit l, input bit r);
    bus0.din = d; bus0.din_valid = v; bus0.last = l;
    bus1.din = d; bus1.din_valid = v; bus1.last = l;
    bus2.din = d; bus2.din_valid = v; bus2.last = l;
    rst = r;
    model_step(d, v, l, r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic feed_round(input logic [15:0] d, input bit l);
    for (int k = 0; k < 4; k++) cycle(d, 1'b1, l && (k == 3), 1'b0);
  endtask

  initial begin
    int nvalid;
    logic [15:0] rd;

    vecs[0].din = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
    vecs[0].rounds = 3;
    vecs[0].exp = {32'h000C0000, 32'h000C0000, 32'h000C0000, 32'h000C0000};
    vecs[1].din = {16'hE000, 16'hE800, 16'hF000, 16'hF800};
    vecs[1].rounds = 2;
    vecs[1].exp = {32'hFFF00000, 32'hFFF40000, 32'hFFF80000, 32'hFFFC0000};
    vecs[2].din = {16'h0000, 16'h0001, 16'h8000, 16'h7FFF};
    vecs[2].rounds = 1;
    vecs[2].exp = {32'h00000000, 32'h00000040, 32'hFFE00000, 32'h001FFFC0};

    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(16'h0000, 1'b1, 1'b1, 1'b1);
    check("reset.valid", longint'(bus0.dout_valid), 0);
    check("reset.dout", longint'(bus0.dout), 0);

    for (int v = 0; v < 3; v++) begin
      for (int r = 0; r < vecs[v].rounds; r++) begin
        for (int k = 0; k < 4; k++) begin
          cycle(vecs[v].din[k], 1'b1, (r == vecs[v].rounds - 1) && (k == 3), 1'b0);
        end
      end
      for (int k = 0; k < 4; k++) begin
        cycle(16'h0000, 1'b0, 1'b0, 1'b0);
        check($sformatf("vec%0d.valid%0d", v, k), longint'(bus0.dout_valid), 1);
        check($sformatf("vec%0d.dout%0d", v, k), longint'(bus0.dout), longint'(vecs[v].exp[k]));
        check($sformatf("vec%0d.ch%0d", v, k), longint'(bus0.dout_ch), longint'(k));
        check($sformatf("vec%0d.ovf%0d", v, k), longint'(bus0.dout_ovf), 0);
      end
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    end

    // Back-to-back four-sample frames; the second dump must not contain the first frame.
    feed_round(16'h1000, 1'b1);
    feed_round(16'h0800, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
      check($sformatf("b2b.dout%0d", k), longint'(bus0.dout), 64'h20000);
      check($sformatf("b2b.ch%0d", k), longint'(bus0.dout_ch), longint'(k));
    end
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);

    // last on channel 1 is ignored: no dump, and the frame keeps accumulating.
    cycle(16'h0100, 1'b1, 1'b0, 1'b0);
    cycle(16'h0100, 1'b1, 1'b1, 1'b0);
    cycle(16'h0100, 1'b1, 1'b0, 1'b0);
    cycle(16'h0100, 1'b1, 1'b0, 1'b0);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
      nvalid += int'(bus0.dout_valid);
    end
    check("ignored_last.valid_count", longint'(nvalid), 0);
    feed_round(16'h0040, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
      check($sformatf("ignored_last.dout%0d", k), longint'(bus0.dout), 64'h5000);
    end
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset during the third cycle of a dump aborts it; next frame restarts at ch0.
    feed_round(16'h1000, 1'b1);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b1);
    check("abort.valid", longint'(bus0.dout_valid), 0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(16'((k + 1) * 16'h0200), 1'b1, k == 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(16'h0000, 1'b0, 1'b0, 1'b0);
      check($sformatf("abort.next_ch%0d", k), longint'(bus0.dout_ch), longint'(k));
      check($sformatf("abort.next_dout%0d", k), longint'(bus0.dout), longint'((k + 1) * 32'h8000));
    end
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);

    // 20-bit instances: 17 rounds of 0x7FFF exceed +2^19-1.
    for (int r = 0; r < 17; r++) feed_round(16'h7FFF, r == 16);
    cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    check("sat.dout", longint'(bus1.dout), 64'h7FFFF);
    check("sat.ovf", longint'(bus1.dout_ovf), 1);
    check("wrap.dout", longint'(bus2.dout), 64'h87FEF);
    check("wrap.sign", longint'(bus2.dout[19]), 1);
    check("wrap.ovf", longint'(bus2.dout_ovf), 1);
    for (int k = 0; k < 4; k++) cycle(16'h0000, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      rd = 16'($urandom);
      cycle(rd, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end
    for (int k = 0; k < 8; k++) cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    check("drain.pending", longint'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_sig_acc.md
MULTI_SIG_ACC -- requirements
Module: multi_sig_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16, input word width in bits.
REQ-002 SHALL have parameter DIN_INT, default 4, input integer bits; input fraction bits DF = DIN_WIDTH-DIN_INT.
REQ-003 SHALL have parameter DOUT_WIDTH, default 32, output and accumulator width in bits.
REQ-004 SHALL have parameter DOUT_INT, default 14, output integer bits; output fraction bits OF = DOUT_WIDTH-DOUT_INT.
REQ-005 SHALL have parameter CHANNELS, default 4, number of interleaved channels, minimum 2.
REQ-006 SHALL have parameter SATURATE, default 1; 1 clamps on overflow, 0 wraps.
REQ-007 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port din, input, DIN_WIDTH bits, signed input sample.
REQ-010 SHALL have port din_valid, input, 1 bit, qualifies din.
REQ-011 SHALL have port last, input, 1 bit, marks the final round of a frame.
REQ-012 SHALL have port dout, output, DOUT_WIDTH bits, signed channel sum.
REQ-013 SHALL have port dout_ch, output, max(1,$clog2(CHANNELS)) bits, channel index of dout.
REQ-014 SHALL have port dout_valid, output, 1 bit, qualifies dout, dout_ch and dout_ovf.
REQ-015 SHALL have port dout_ovf, output, 1 bit, sticky overflow flag for the reported channel.

Function
REQ-016 SHALL feed samples round-robin: channel counter ch_cnt starts at 0, advances on each din_valid, and wraps from CHANNELS-1 to 0.
REQ-017 SHALL align each sample as sign-extend to DOUT_WIDTH, then shift left by OF-DF.
REQ-018 SHALL reject at elaboration any configuration where DOUT_INT < DIN_INT or OF < DF.
REQ-019 SHALL, on din_valid, update acc[ch_cnt]: load the aligned sample on the first round of a frame, otherwise add it.
REQ-020 SHALL compute each sum at DOUT_WIDTH+1 bits; overflow is declared when the top two bits differ.
REQ-021 SHALL, on overflow with SATURATE=1, clamp the sum to the most positive or most negative DOUT_WIDTH value.
REQ-022 SHALL, on overflow with SATURATE=0, keep the low DOUT_WIDTH bits (wrap).
REQ-023 SHALL, in either overflow mode, set the channel's ovf bit sticky until the frame is dumped.
REQ-024 SHALL honour last only when din_valid=1 and ch_cnt=CHANNELS-1; last is ignored at all other times.
REQ-025 SHALL, on an honoured last at cycle t, copy all final sums and ovf bits into a shadow bank at the edge ending cycle t, including channel CHANNELS-1's own final update.
REQ-026 SHALL, on the same edge, mark the next round as a first round (reload) with no idle cycle required.
REQ-027 SHALL use a two-state FSM: IDLE goes to DUMP on an honoured last; DUMP returns to IDLE after channel CHANNELS-1 is emitted.
REQ-028 SHALL, in DUMP, emit the shadow entries one per cycle in order ch 0..CHANNELS-1.
REQ-029 SHALL assert dout_valid in cycles t+2 .. t+CHANNELS+1, registered, with no gaps.
REQ-030 SHALL keep accepting and accumulating input during DUMP; a frame is at least CHANNELS samples, so the shadow bank is never overwritten mid-dump.
REQ-031 SHALL hold dout, dout_ch and dout_ovf at 0 whenever dout_valid=0.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set all outputs to 0, ch_cnt to 0, FSM to IDLE, and all ovf bits to 0, and set the first-round flag.
REQ-033 SHALL, on rst asserted mid-dump, abort the dump; dout_valid SHALL be 0 from the next cycle, and no further results from that frame are emitted.
REQ-034 SHALL give reset priority over din_valid and last asserted in the same cycle.

Structure
REQ-035 SHALL place no typedefs in a shared package; the alignment shift (OF-DF) and the saturation limits are localparams of this module.
REQ-036 SHALL instantiate one sub-module, sig_sat_add: a combinational DOUT_WIDTH signed adder with a SATURATE parameter and an overflow output, used for the REQ-020..022 arithmetic.
REQ-037 SHALL hold accumulators and the shadow bank in register arrays of depth CHANNELS (no RAM inference required).

Verification
REQ-038 SHALL cover: defaults, din=0x1000 (1.0) on all 4 channels for 3 rounds, last on the final ch3 -> dout=0x000C0000 for ch0..3, dout_ovf=0, valid at t+2..t+5.
REQ-039 SHALL cover: ch k fed value -(k+1)*0x0800, 2 rounds -> dout = -(k+1)<<18 (ch0 0xFFFC0000), dout_ovf=0.
REQ-040 SHALL cover: DOUT_WIDTH=20, DOUT_INT=8, din=0x7FFF repeated -> SATURATE=1 pins dout at 0x7FFFF with dout_ovf=1; SATURATE=0 wraps negative with dout_ovf=1.
REQ-041 SHALL cover: back-to-back frames of exactly 4 samples with gaps-free din_valid -> every dump is complete and correct, and the second frame's sums exclude the first frame.
REQ-042 SHALL cover: last asserted with ch_cnt=1 -> ignored, no dump; rst asserted during dump cycle t+3 -> dout_valid=0 from t+4, and the next frame starts at ch0.
